fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the WISC-style core: owns the architectural PC register, requests instructions from instruction memory over a request/valid handshake, and presents one instruction at a time to decode and to the PC control block. The PC control block consumes `pc_current` and `instr_out` and returns `pc_new`. The fetch unit latches `pc_new` when the presented instruction retires. It also detects HLT, freezes the core, and keeps a retired-instruction count.

## Interface
- `RESET_PC`, default 16'h0000, PC value loaded on reset.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `pc_new` input 16: next PC computed by PC control from `pc_current` and `instr_out`.
- `stall_in` input 1: downstream hazard stall; 1 = do not consume the presented instruction.
- `imem_data` input 16: instruction word from instruction memory.
- `imem_valid` input 1: `imem_data` valid for the outstanding request.
- `imem_req` output 1: fetch request; address on `imem_addr`.
- `imem_addr` output 16: fetch address, always equal to `pc_current`.
- `pc_current` output 16: architectural PC of the presented or pending instruction.
- `instr_out` output 16: captured instruction word.
- `instr_valid` output 1: `instr_out` is presented to decode/PC control.
- `halted` output 1: HLT retired; core frozen.
- `retired_count` output 16: number of instructions consumed, wraps modulo 2^16.

## Operation
- **Reset values** (async, while `rst_n`=0):
  - PC = `RESET_PC` with bit 0 forced to 0.
  - State = FETCH.
  - `imem_req` = 0, `instr_out` = 16'h0000, `instr_valid` = 0, `halted` = 0, `retired_count` = 0.
- **State FETCH:**
  - `imem_req` = 1 combinationally (0 while in reset). `imem_addr` = PC, held stable until the response.
  - On `imem_valid`=1 at an edge: `instr_out` <= `imem_data`, go to ISSUE.
  - `stall_in` is ignored in FETCH.
- **State ISSUE:**
  - `imem_req` = 0, `instr_valid` = 1.
  - At an edge with `stall_in`=0, the instruction is consumed:
    - PC <= {`pc_new`[15:1], 1'b0}.
    - `retired_count` increments by 1, wrapping 16'hFFFF to 16'h0000.
    - If `instr_out`[15:12] == 4'b1111, go to HALT and leave PC unchanged (`pc_new` is ignored). Otherwise go to FETCH.
  - With `stall_in`=1: hold everything, including `instr_out`, PC and the count.
- **State HALT:**
  - `halted` = 1, `instr_valid` = 0, `imem_req` = 0.
  - PC, `instr_out` and the count are frozen.
  - Only `rst_n` exits this state.
- `imem_valid` outside FETCH is ignored, with no state change.
- `pc_new` is sampled only on the consuming edge of a non-HLT instruction. It may change freely at all other times.
- Instruction memory shares `rst_n`. Any `imem_valid` seen in FETCH is treated as the response to the current `imem_addr`.
- Reset mid-operation, in any state: immediate return to the reset values. An in-flight request is abandoned and refetched from `RESET_PC`.

## Timing
- Earliest response: `imem_valid` one cycle after `imem_req` rises. Request cycle N, capture edge end of N+1, `instr_valid` high in N+2.
- With no stall and 1-cycle memory, one instruction every 3 cycles: FETCH, WAIT (still FETCH), ISSUE.
- Memory latency L ≥ 1 cycles adds L−1 FETCH cycles.
- Each `stall_in` cycle in ISSUE adds exactly one cycle.
- `pc_current`, `instr_out` and `retired_count` are registered outputs. `imem_req` and `instr_valid` decode from the state register only, with no combinational path from any input.
- `halted` rises the cycle after the consuming edge of HLT.

## Test plan
- **Reset and fetch:** release reset, memory returns 16'hA123 one cycle after request → `imem_addr`=0x0000, `instr_valid` high on the 3rd cycle after release with `instr_out`=16'hA123.
- **Sequential flow:** `pc_new` = `pc_current`+2 for 4 instructions → `imem_addr` sequence 0x0000, 0x0002, 0x0004, 0x0006; `retired_count`=4.
- **Branch redirect:** `pc_new`=16'h0041 on the consume edge → next `imem_addr`=16'h0040.
- **Stall plus slow memory:** memory latency 3 and `stall_in` high 2 cycles in ISSUE → `instr_out` and PC stable throughout; 7 cycles per instruction.
- **Halt:** present 16'hF000 → `halted`=1 next cycle, `imem_req` stays 0, PC unchanged, later `imem_valid` pulses ignored.
- **Mid-flight reset and wrap:**
  - Assert `rst_n` low while in FETCH awaiting the response → all outputs return to reset values immediately.
  - Preload the count to 16'hFFFF by running 65535 instructions, then retire one more → `retired_count`=16'h0000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the architectural PC, fetches one instruction
// at a time over a req/valid handshake, presents it to decode/PC control,
// detects HLT and counts retired instructions.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_new,
  input  logic        stall_in,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] pc_current,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] retired_count
);

  localparam int unsigned W = 16;
  localparam logic [3:0]   HLT_OPCODE = 4'b1111;
  localparam logic [W-1:0] PC_ALIGN   = 16'hFFFE;
  localparam logic [W-1:0] PC_RESET   = RESET_PC & PC_ALIGN;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic           run_q;
  logic [W-1:0]   pc_d;
  logic [W-1:0]   instr_d;
  logic [W-1:0]   count_d;

  // Request/valid/halt decode straight from flops; run_q keeps the request
  // low while reset is held without a path from rst_n.
  assign imem_req    = run_q && (state_q == ST_FETCH);
  assign instr_valid = (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALT);
  assign imem_addr   = pc_current;

  // Goes high on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  // State, PC, instruction and retire-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      pc_current    <= PC_RESET;
      instr_out     <= '0;
      retired_count <= '0;
    end else begin
      state_q       <= state_d;
      pc_current    <= pc_d;
      instr_out     <= instr_d;
      retired_count <= count_d;
    end
  end

  // Next-state and datapath update; HLT retires without taking pc_new.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_current;
    instr_d = instr_out;
    count_d = retired_count;
    case (state_q)
      ST_FETCH: begin
        if (run_q && imem_valid) begin
          instr_d = imem_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!stall_in) begin
          count_d = retired_count + W'(1);
          if (instr_out[15:12] == HLT_OPCODE) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_new & PC_ALIGN;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of instructions driven through a
// small memory responder, plus hand sequences for halt, mid-flight reset
// and retire-count wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_new;
  logic        stall_in;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] pc_current;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        halted;
  logic [15:0] retired_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .pc_new(pc_new), .stall_in(stall_in),
    .imem_data(imem_data), .imem_valid(imem_valid), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc_current(pc_current), .instr_out(instr_out),
    .instr_valid(instr_valid), .halted(halted), .retired_count(retired_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          stall;
    logic [15:0] pcn;
    logic [15:0] exp_addr;
    int          exp_cyc;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Waits for a request, answers after lat cycles, holds ISSUE for stall
  // cycles, then consumes with pc_new = pcn. Returns request address and
  // cycles from request to the cycle after the consuming edge.
  task automatic do_instr(input logic [15:0] data, input int lat, input int stall,
                          input logic [15:0] pcn, output logic [15:0] addr,
                          output int cycles);
    int  start;
    bit  seen;
    seen   = 1'b0;
    addr   = 16'h0;
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    start = cyc;
    addr  = imem_addr;
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      chk("addr_hold", 32'(imem_addr), 32'(addr));
      chk("no_valid_in_fetch", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    imem_valid = 1'b1;
    imem_data  = data;
    @(negedge clk);
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr_out", 32'(instr_out), 32'(data));
    chk("req_low_issue", 32'(imem_req), 32'd0);
    for (int s = 0; s < stall; s++) begin
      stall_in   = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 16'h0BAD;
      pc_new     = 16'hBEEF;
      @(negedge clk);
      chk("stall_instr", 32'(instr_out), 32'(data));
      chk("stall_pc", 32'(pc_current), 32'(addr));
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall_in   = 1'b0;
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    pc_new     = pcn;
    @(negedge clk);
    pc_new = 16'hDEAD;
    cycles = cyc - start;
  endtask

  initial begin
    logic [15:0] a;
    int          c;

    //        data     lat st pc_new   addr     cyc cnt
    vecs[0] = '{16'hA123, 1, 0, 16'h0002, 16'h0000, 3, 16'd1};
    vecs[1] = '{16'h1111, 1, 0, 16'h0004, 16'h0002, 3, 16'd2};
    vecs[2] = '{16'h2222, 1, 0, 16'h0006, 16'h0004, 3, 16'd3};
    vecs[3] = '{16'h3333, 1, 0, 16'h0041, 16'h0006, 3, 16'd4};
    vecs[4] = '{16'h4444, 3, 2, 16'h0047, 16'h0040, 7, 16'd5};
    vecs[5] = '{16'h5555, 2, 1, 16'h0048, 16'h0046, 5, 16'd6};
    vecs[6] = '{16'hF000, 1, 0, 16'h1234, 16'h0048, 3, 16'd7};

    rst_n      = 1'b0;
    pc_new     = 16'h0000;
    stall_in   = 1'b0;
    imem_data  = 16'h0000;
    imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_pc", 32'(pc_current), 32'h0);
    chk("rst_instr", 32'(instr_out), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(retired_count), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_instr(vecs[i].data, vecs[i].lat, vecs[i].stall, vecs[i].pcn, a, c);
      chk($sformatf("v%0d_addr", i), 32'(a), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_cycles", i), 32'(c), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_count", i), 32'(retired_count), 32'(vecs[i].exp_cnt));
    end

    // Halt: frozen, no requests, late responses ignored.
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_pc", 32'(pc_current), 32'h0048);
    imem_valid = 1'b1;
    imem_data  = 16'h0BAD;
    pc_new     = 16'h0100;
    repeat (3) @(negedge clk);
    imem_valid = 1'b0;
    chk("halt_req", 32'(imem_req), 32'd0);
    chk("halt_hold", 32'(halted), 32'd1);
    chk("halt_pc_hold", 32'(pc_current), 32'h0048);
    chk("halt_instr_hold", 32'(instr_out), 32'hF000);
    chk("halt_count_hold", 32'(retired_count), 32'd7);

    // Reset out of HALT, run one instruction, then reset while awaiting data.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_instr(16'h7777, 1, 0, 16'h0010, a, c);
    chk("rerun_addr", 32'(a), 32'h0000);
    chk("rerun_cycles", 32'(c), 32'd3);
    @(negedge clk);
    chk("inflight_req", 32'(imem_req), 32'd1);
    chk("inflight_addr", 32'(imem_addr), 32'h0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_pc", 32'(pc_current), 32'h0);
    chk("mid_rst_instr", 32'(instr_out), 32'h0);
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_count", 32'(retired_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Retire-count wrap: preload FFFF while in FETCH, retire one more.
    @(negedge clk);
    force dut.retired_count = 16'hFFFF;
    @(negedge clk);
    release dut.retired_count;
    do_instr(16'h0123, 1, 0, 16'h0002, a, c);
    chk("refetch_addr", 32'(a), 32'h0000);
    chk("wrap_count", 32'(retired_count), 32'h0000);
    do_instr(16'h0456, 2, 0, 16'h0004, a, c);
    chk("post_wrap_addr", 32'(a), 32'h0002);
    chk("post_wrap_count", 32'(retired_count), 32'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
